// File: rtl/instr_reader.sv
// Instruction register scanner: reads a run of register entries,
// recomputes each expected result and streams words with a mismatch flag.

package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
    } opcode_t;
    typedef logic [7:0]  operand_t;
    typedef logic [15:0] result_t;
    typedef logic [4:0]  address_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t operand_a;
        operand_t operand_b;
        result_t  result;
    } instruction_t;
endpackage

module instr_reader
    import instr_register_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_word,
    output logic         out_mismatch,
    output logic         busy,
    output logic         done,
    output logic [5:0]   err_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]   state_q, state_d;
    address_t     ptr_q, ptr_d;
    address_t     rp_q, rp_d;
    logic [5:0]   rem_q, rem_d;
    instruction_t word_q, word_d;
    logic         mism_q, mism_d;
    logic [5:0]   err_q, err_d;

    result_t      a16, b16, exp_res;
    logic         known, chk;
    logic [5:0]   cnt_clamp;

    // Recompute the expected result of the word on the read port
    always_comb begin
        a16     = {8'h00, instruction_word.operand_a};
        b16     = {8'h00, instruction_word.operand_b};
        exp_res = '0;
        known   = 1'b1;
        case (instruction_word.opc)
            ZERO:    exp_res = '0;
            PASSA:   exp_res = a16;
            PASSB:   exp_res = b16;
            ADD:     exp_res = a16 + b16;
            SUB:     exp_res = a16 - b16;
            MULT:    exp_res = a16 * b16;
            DIV:     exp_res = (b16 == '0) ? '0 : a16 / b16;
            MOD:     exp_res = (b16 == '0) ? '0 : a16 % b16;
            POW:     exp_res = a16 ** b16;
            default: known   = 1'b0;
        endcase
        chk = CHECK_EN & known & (exp_res != instruction_word.result);
    end

    // Scan sequencer: next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rp_d      = rp_q;
        rem_d     = rem_q;
        word_d    = word_q;
        mism_d    = mism_q;
        err_d     = err_q;
        cnt_clamp = (count > 6'd32) ? 6'd32 : count;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = start_addr;
                    rem_d   = cnt_clamp;
                    err_d   = '0;
                    state_d = (cnt_clamp != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                rp_d    = ptr_q;
                word_d  = instruction_word;
                mism_d  = chk;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (mism_q && err_q != 6'd63)
                        err_d = err_q + 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        rem_d   = rem_q - 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rp_q    <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            mism_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rp_q    <= rp_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

    assign read_pointer = (state_q == S_FETCH) ? ptr_q : rp_q;
    assign out_valid    = (state_q == S_PRESENT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign out_word     = word_q;
    assign out_mismatch = mism_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_instr_reader.sv
// Scoreboard bench for instr_reader: reference model of the scan and
// result checking, one checked and one unchecked instance side by side.
`timescale 1ns/1ps

module tb_instr_reader;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    address_t start_addr = '0;
    logic [5:0] count = '0;

    instruction_t mem [32];

    address_t rp1, rp0;
    instruction_t iw1, iw0, ow1, ow0;
    logic ov1, ov0, om1, om0, busy1, busy0, done1, done0;
    logic [5:0] ec1, ec0;

    assign iw1 = mem[rp1];
    assign iw0 = mem[rp0];

    instr_reader #(.CHECK_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_addr(start_addr), .count(count),
        .read_pointer(rp1), .instruction_word(iw1),
        .out_valid(ov1), .out_ready(out_ready),
        .out_word(ow1), .out_mismatch(om1),
        .busy(busy1), .done(done1), .err_count(ec1)
    );

    instr_reader #(.CHECK_EN(1'b0)) dut_nc (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_addr(start_addr), .count(count),
        .read_pointer(rp0), .instruction_word(iw0),
        .out_valid(ov0), .out_ready(out_ready),
        .out_word(ow0), .out_mismatch(om0),
        .busy(busy0), .done(done0), .err_count(ec0)
    );

    always #5 clk = ~clk;

    typedef struct {
        instruction_t w;
        logic         m;
        address_t     a;
    } exp_t;

    exp_t sb_q[$];
    int   err_q[$];
    exp_t e;
    int   rmode = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_res(instruction_t w);
        longint unsigned a = longint'(w.operand_a);
        longint unsigned b = longint'(w.operand_b);
        longint unsigned r;
        case (int'(w.opc))
            0: r = 0;
            1: r = a;
            2: r = b;
            3: r = a + b;
            4: r = a - b;
            5: r = a * b;
            6: r = (b == 0) ? 0 : a / b;
            7: r = (b == 0) ? 0 : a % b;
            8: begin
                r = 1;
                for (int i = 0; i < int'(b); i++) r = (r * a) & 64'hFFFF;
            end
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic ref_mis(instruction_t w);
        if (int'(w.opc) > 8) return 1'b0;
        return ref_res(w) != w.result;
    endfunction

    function automatic instruction_t rand_instr();
        instruction_t w;
        w.opc       = opcode_t'($urandom_range(0, 15));
        w.operand_a = operand_t'($urandom);
        w.operand_b = operand_t'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        w.result    = result_t'($urandom);
        if ($urandom_range(0, 1) == 1) w.result = ref_res(w);
        return w;
    endfunction

    // out_ready driver: always high, random, or held low
    always @(posedge clk) begin
        #2;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each transfer and each done pulse
    always @(negedge clk) begin
        if (reset_n) begin
            if (ov1 && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL xfer: unexpected transfer of %0h", ow1);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_word", 64'(ow1), 64'(e.w));
                    chk("out_mismatch", 64'(om1), 64'(e.m));
                    chk("read_pointer", 64'(rp1), 64'(e.a));
                end
            end
            if (ov0) chk("mismatch_unchecked", 64'(om0), 64'd0);
            if (done1) begin
                done_cnt++;
                chk("valid_in_done", 64'(ov1), 64'd0);
                n_vec++;
                if (err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL done: unexpected pulse, err_count %0d", ec1);
                end else begin
                    chk("err_count", 64'(ec1), 64'(err_q.pop_front()));
                end
            end
            if (done0) chk("err_unchecked", 64'(ec0), 64'd0);
        end
    end

    task automatic check_reset_vals(string tag);
        chk({tag, "_rp"}, 64'(rp1), 64'd0);
        chk({tag, "_valid"}, 64'(ov1), 64'd0);
        chk({tag, "_word"}, 64'(ow1), 64'd0);
        chk({tag, "_mism"}, 64'(om1), 64'd0);
        chk({tag, "_busy"}, 64'(busy1), 64'd0);
        chk({tag, "_done"}, 64'(done1), 64'd0);
        chk({tag, "_err"}, 64'(ec1), 64'd0);
    endtask

    // Queue expectations and pulse start; returns at edge N + 1ns
    task automatic issue(address_t a, logic [5:0] c, output int n);
        int errs = 0;
        address_t ad;
        logic m;
        n = (c > 6'd32) ? 32 : int'(c);
        for (int i = 0; i < n; i++) begin
            ad = address_t'((int'(a) + i) % 32);
            m = ref_mis(mem[ad]);
            sb_q.push_back('{mem[ad], m, ad});
            errs += int'(m);
        end
        err_q.push_back(errs);
        start_addr = a;
        count = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_addr = address_t'($urandom);
        count = 6'($urandom);
    endtask

    task automatic wait_done(int base);
        for (int k = 0; k < 400 && done_cnt == base; k++) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - base), 64'd1);
        chk("queue_drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic scan(address_t a, logic [5:0] c);
        int n;
        int base = done_cnt;
        issue(a, c, n);
        @(negedge clk);
        chk("busy_n1", 64'(busy1), 64'd1);
        chk("valid_n1", 64'(ov1), 64'd0);
        if (n > 0) begin
            @(negedge clk);
            chk("valid_n2", 64'(ov1), 64'd1);
        end
        wait_done(base);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        for (int i = 0; i < 32; i++) mem[i] = rand_instr();

        start = 1'b1;
        count = 6'd3;
        start_addr = 5'd5;
        #23;
        check_reset_vals("reset");
        start = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy1), 64'd0);
        check_reset_vals("release");
        @(posedge clk);
        #1;

        mem[2] = '{ADD, 8'd5, 8'd3, 16'd8};
        scan(5'd2, 6'd1);

        scan(5'd30, 6'd4);

        mem[0] = '{ADD, 8'd5, 8'd3, 16'd10};
        mem[1] = '{DIV, 8'd7, 8'd0, 16'd0};
        scan(5'd0, 6'd2);

        scan(5'd9, 6'd0);

        rmode = 2;
        @(posedge clk);
        #1;
        base = done_cnt;
        issue(5'd4, 6'd2, n);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            start_addr = 5'd9;
            count = 6'd7;
            @(negedge clk);
            chk("hold_valid", 64'(ov1), 64'd1);
            chk("hold_word", 64'(ow1), 64'(mem[4]));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rmode = 0;
        wait_done(base);

        rmode = 2;
        @(posedge clk);
        #1;
        issue(5'd3, 6'd5, n);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_valid", 64'(ov1), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        sb_q.delete();
        err_q.delete();
        base = done_cnt;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rmode = 0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(base));
        chk("abort_idle", 64'(busy1), 64'd0);
        @(posedge clk);
        #1;

        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_instr();
            rmode = $urandom_range(0, 1);
            scan(address_t'($urandom), 6'($urandom_range(0, 40)));
        end
        rmode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
